// File: rtl/display_pkg.sv
// display_pkg: shared state encoding, segment constants and BCD helper for the result display
package display_pkg;

    typedef enum logic [1:0] {
        OCIOSO,
        CONVERTE,
        GRAVA
    } estado_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MENOS = 7'b0111111;
    localparam int         N_DIG     = 5;
    localparam int         N_POS     = 6;
    localparam int         N_BITS    = 14;
    localparam int         BCD_W     = 4 * N_DIG;

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift
    function automatic logic [BCD_W-1:0] soma3(input logic [BCD_W-1:0] a);
        logic [BCD_W-1:0] r;
        r = a;
        for (int k = 0; k < N_DIG; k++)
            r[4*k +: 4] = (a[4*k +: 4] >= 4'd5) ? a[4*k +: 4] + 4'd3 : a[4*k +: 4];
        return r;
    endfunction

endpackage

// File: rtl/decod_7seg.sv
// decod_7seg: BCD digit to active-low {g,f,e,d,c,b,a} segments, with blanking
module decod_7seg
    import display_pkg::*;
(
    input  logic [3:0] digito_i,
    input  logic       apaga_i,
    output logic [6:0] seg_o
);

    // Segment lookup; non-decimal codes and blanked digits show nothing
    always_comb begin
        seg_o = SEG_BLANK;
        if (!apaga_i) begin
            case (digito_i)
                4'd0:    seg_o = 7'h40;
                4'd1:    seg_o = 7'h79;
                4'd2:    seg_o = 7'h24;
                4'd3:    seg_o = 7'h30;
                4'd4:    seg_o = 7'h19;
                4'd5:    seg_o = 7'h12;
                4'd6:    seg_o = 7'h02;
                4'd7:    seg_o = 7'h78;
                4'd8:    seg_o = 7'h00;
                4'd9:    seg_o = 7'h10;
                default: seg_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/display_resultado.sv
// display_resultado: double-dabble conversion of the result and multiplexed 6-position display
module display_resultado
    import display_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] Y,
    input  logic        sinal,
    input  logic        EN,
    output logic [6:0]  seg,
    output logic [5:0]  an,
    output logic [19:0] bcd,
    output logic        pronto
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    estado_t          estado_q, estado_d;
    logic [13:0]      shift_q, shift_d;
    logic [19:0]      acc_q, acc_d;
    logic [3:0]       it_q, it_d;
    logic             pend_q, pend_d;
    logic             sinal_q, sinal_d;
    logic             valido_q, valido_d;
    logic [14:0]      ultimo_q, ultimo_d;
    logic [19:0]      bcd_q, bcd_d;
    logic             pronto_q, pronto_d;
    logic [6:0]       seg_q, seg_d;
    logic [5:0]       an_q, an_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic [2:0]       idx_q, idx_d;
    logic [3:0]       digito;
    logic             apaga;
    logic             ligado;
    logic             pre_wrap;
    logic [6:0]       seg_dec;

    // Conversion FSM: sample on change, 14 shift-and-add-3 steps, then commit
    always_comb begin
        estado_d = estado_q;
        shift_d  = shift_q;
        acc_d    = acc_q;
        it_d     = it_q;
        pend_d   = pend_q;
        sinal_d  = sinal_q;
        valido_d = valido_q;
        ultimo_d = ultimo_q;
        bcd_d    = bcd_q;
        pronto_d = 1'b0;
        case (estado_q)
            OCIOSO: begin
                if (EN && (!valido_q || {sinal, Y} != ultimo_q)) begin
                    shift_d  = Y;
                    pend_d   = sinal;
                    ultimo_d = {sinal, Y};
                    acc_d    = '0;
                    it_d     = '0;
                    estado_d = CONVERTE;
                end
            end
            CONVERTE: begin
                {acc_d, shift_d} = {soma3(acc_q), shift_q} << 1;
                it_d = it_q + 4'd1;
                if (it_q == 4'(N_BITS - 1)) estado_d = GRAVA;
            end
            GRAVA: begin
                bcd_d    = acc_q;
                sinal_d  = pend_q;
                valido_d = 1'b1;
                pronto_d = 1'b1;
                estado_d = OCIOSO;
            end
            default: estado_d = OCIOSO;
        endcase
        if (!EN) valido_d = 1'b0;
    end

    assign pre_wrap = pre_q == PW'(SCAN_DIV - 1);
    assign digito   = 4'(bcd_q >> {idx_q, 2'b00});
    assign apaga    = (idx_q != 3'd0) && ((bcd_q >> {idx_q, 2'b00}) == 20'd0);
    assign ligado   = EN && valido_q;

    decod_7seg u_decod (
        .digito_i (digito),
        .apaga_i  (apaga),
        .seg_o    (seg_dec)
    );

    // Scan prescaler, position select and the registered segment/anode drive
    always_comb begin
        pre_d = pre_wrap ? '0 : pre_q + 1'b1;
        idx_d = pre_wrap ? ((idx_q == 3'(N_POS - 1)) ? 3'd0 : idx_q + 3'd1) : idx_q;
        an_d  = ligado ? ~(6'd1 << idx_q) : 6'h3F;
        seg_d = !ligado ? SEG_BLANK :
                (idx_q == 3'(N_POS - 1)) ? ((sinal_q && bcd_q != 20'd0) ? SEG_MENOS : SEG_BLANK) :
                seg_dec;
    end

    // State registers; reset aborts any conversion and blanks the display
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= OCIOSO;
            shift_q  <= '0;
            acc_q    <= '0;
            it_q     <= '0;
            pend_q   <= 1'b0;
            sinal_q  <= 1'b0;
            valido_q <= 1'b0;
            ultimo_q <= '0;
            bcd_q    <= '0;
            pronto_q <= 1'b0;
            seg_q    <= SEG_BLANK;
            an_q     <= 6'h3F;
            pre_q    <= '0;
            idx_q    <= '0;
        end else begin
            estado_q <= estado_d;
            shift_q  <= shift_d;
            acc_q    <= acc_d;
            it_q     <= it_d;
            pend_q   <= pend_d;
            sinal_q  <= sinal_d;
            valido_q <= valido_d;
            ultimo_q <= ultimo_d;
            bcd_q    <= bcd_d;
            pronto_q <= pronto_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
            pre_q    <= pre_d;
            idx_q    <= idx_d;
        end
    end

    assign seg    = seg_q;
    assign an     = an_q;
    assign bcd    = bcd_q;
    assign pronto = pronto_q;

endmodule

// File: tb/tb_display_resultado.sv
// tb_display_resultado: random and directed stimulus checked against a behavioural display model
module tb_display_resultado;

    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [13:0] Y = '0;
    logic        sinal = 1'b0;
    logic        EN = 1'b0;
    logic [6:0]  seg;
    logic [5:0]  an;
    logic [19:0] bcd;
    logic        pronto;

    int n_chk = 0;
    int n_fail = 0;

    display_resultado #(.SCAN_DIV(SD)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .Y      (Y),
        .sinal  (sinal),
        .EN     (EN),
        .seg    (seg),
        .an     (an),
        .bcd    (bcd),
        .pronto (pronto)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r = '0;
        int p = 1;
        for (int k = 0; k < 5; k++) begin
            r = r | (20'((v / p) % 10) << (4 * k));
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] pos_seg(input int p, input int v, input bit neg);
        int pw = 1;
        if (p == 5) return (neg && v != 0) ? 7'h3F : 7'h7F;
        for (int k = 0; k < p; k++) pw = pw * 10;
        if (p > 0 && v < pw) return 7'h7F;
        return seg_of((v / pw) % 10);
    endfunction

    // Behavioural model: latency countdown, committed value, scan position
    int          m_rem, m_val, m_pend_v, m_pre, m_idx;
    bit          m_neg, m_pend_s, m_valid, m_pronto;
    logic [14:0] m_last;
    logic [6:0]  m_seg;
    logic [5:0]  m_an;

    initial begin
        m_rem = 0; m_val = 0; m_pend_v = 0; m_pre = 0; m_idx = 0;
        m_neg = 0; m_pend_s = 0; m_valid = 0; m_pronto = 0;
        m_last = '0; m_seg = 7'h7F; m_an = 6'h3F;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_rem = 0; m_val = 0; m_pre = 0; m_idx = 0;
                m_neg = 0; m_valid = 0; m_pronto = 0;
                m_seg = 7'h7F; m_an = 6'h3F;
            end else begin
                if (EN && m_valid) begin
                    m_an  = ~(6'd1 << m_idx);
                    m_seg = pos_seg(m_idx, m_val, m_neg);
                end else begin
                    m_an  = 6'h3F;
                    m_seg = 7'h7F;
                end
                m_pronto = 0;
                if (m_rem == 0) begin
                    if (EN && (!m_valid || {sinal, Y} != m_last)) begin
                        m_last   = {sinal, Y};
                        m_pend_v = int'(Y);
                        m_pend_s = sinal;
                        m_rem    = 15;
                    end
                end else begin
                    m_rem--;
                    if (m_rem == 0) begin
                        m_val    = m_pend_v;
                        m_neg    = m_pend_s;
                        m_valid  = 1;
                        m_pronto = 1;
                    end
                end
                if (!EN) m_valid = 0;
                if (m_pre == SD - 1) begin
                    m_pre = 0;
                    m_idx = (m_idx + 1) % 6;
                end else m_pre++;
            end
        end
    end

    // Per-cycle comparison of every output against the model
    initial begin
        forever begin
            @(negedge clk);
            check("seg", seg, m_seg);
            check("an", an, m_an);
            check("bcd", bcd, to_bcd(m_val));
            check("pronto", pronto, m_pronto);
        end
    end

    task automatic wait_pronto(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!pronto && n < 40);
        check("pronto_seen", pronto, 1);
    endtask

    task automatic show(input int p, input logic [6:0] exp, input string nm);
        int t = 0;
        logic [5:0] sel;
        sel = ~(6'd1 << p);
        @(posedge clk);
        do begin
            @(negedge clk);
            t++;
        end while (an !== sel && t < 60);
        check({nm, "_an"}, an, sel);
        check(nm, seg, exp);
    endtask

    int n;
    int cnt;
    logic [6:0] lit [5];

    initial begin
        repeat (3) @(posedge clk);
        #2;
        check("rst_seg", seg, 7'h7F);
        check("rst_an", an, 6'h3F);
        check("rst_bcd", bcd, 20'h0);
        check("rst_pronto", pronto, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        Y = 14'd16129; sinal = 1'b0; EN = 1'b1;
        wait_pronto(n);
        check("lat_first", n, 16);
        check("bcd_16129", bcd, 20'h16129);
        lit[4] = 7'h79; lit[3] = 7'h02; lit[2] = 7'h79; lit[1] = 7'h24; lit[0] = 7'h10;
        for (int p = 4; p >= 0; p--) show(p, lit[p], "dig_16129");
        show(5, 7'h7F, "sign_pos");

        @(posedge clk); #2;
        Y = 14'd5; sinal = 1'b1;
        wait_pronto(n);
        check("bcd_5", bcd, 20'h00005);
        show(0, 7'h12, "dig_5");
        show(5, 7'h3F, "minus_5");
        for (int p = 1; p < 5; p++) show(p, 7'h7F, "lead_blank");

        @(posedge clk); #2;
        Y = 14'd0; sinal = 1'b1;
        wait_pronto(n);
        check("bcd_0", bcd, 20'h0);
        show(0, 7'h40, "dig_0");
        show(5, 7'h7F, "minus_supp");

        @(posedge clk); #2;
        Y = 14'd100; sinal = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        Y = 14'd200;
        wait_pronto(n);
        check("bcd_100", bcd, 20'h00100);
        wait_pronto(n);
        check("lat_second", n, 16);
        check("bcd_200", bcd, 20'h00200);

        repeat (3) @(posedge clk);
        #2;
        EN = 1'b0;
        @(posedge clk);
        #1;
        check("en_off_an", an, 6'h3F);
        check("en_off_seg", seg, 7'h7F);
        repeat (2) @(posedge clk);
        #2;
        EN = 1'b1;
        wait_pronto(n);
        check("lat_reen", n, 16);
        check("bcd_reen", bcd, 20'h00200);

        @(posedge clk); #2;
        Y = 14'd1234;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_seg", seg, 7'h7F);
        check("abort_an", an, 6'h3F);
        check("abort_bcd", bcd, 20'h0);
        check("abort_pronto", pronto, 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        cnt = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (pronto) cnt++;
        end
        check("no_pronto_after_abort", cnt, 0);

        for (int i = 0; i < 250; i++) begin
            @(posedge clk);
            #2;
            EN = ($urandom_range(0, 9) != 0);
            case ($urandom_range(0, 3))
                0: Y = Y;
                1: Y = 14'($urandom_range(0, 20));
                default: Y = 14'($urandom_range(0, 16383));
            endcase
            sinal = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 40)) @(posedge clk);
        end
        repeat (40) @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/display_resultado.md
# display_resultado

Sequential result-display driver for the calculator datapath: consumes the 14-bit magnitude `Y`, the sign flag `sinal` and the display enable `EN` produced by the calculator. It converts the magnitude to five BCD digits with an iterative shift-and-add-3 (double-dabble) engine and drives a six-position, time-multiplexed, active-low seven-segment display. The sign occupies the leftmost position and leading zeros are blanked.

## Interface
- `SCAN_DIV`, default 50000: clock cycles per digit position during scanning (≥2).
- `clk`  input  1  system clock; all state updates on rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `Y`  input  14  result magnitude from the calculator, unsigned.
- `sinal`  input  1  1 = result negative.
- `EN`  input  1  1 = calculator on, display active.
- `seg`  output  7  segments `{g,f,e,d,c,b,a}`, active-low (0 = lit).
- `an`  output  6  position selects, active-low; `an[0]` = units, `an[4]` = ten-thousands, `an[5]` = sign.
- `bcd`  output  20  last committed BCD value, `bcd[3:0]` = units.
- `pronto`  output  1  one-cycle pulse when a new value is committed to `bcd`.

## Operation
- Reset values: `seg`=7'h7F, `an`=6'h3F, `bcd`=0, `pronto`=0, FSM=OCIOSO, scan index=0, prescaler=0, committed sign=0, `valido`=0.
- FSM states: OCIOSO, CONVERTE, GRAVA.
- OCIOSO: if `EN`=1 and (`valido`=0 or `{sinal,Y}` ≠ last sampled `{sinal,Y}`): latch `Y` into the shift register, `sinal` into the pending sign, clear the BCD accumulator, clear the iteration counter, go to CONVERTE.
- CONVERTE: each cycle, first add 3 to every BCD nibble ≥5, then shift `{bcd_acc, shift_reg}` left one bit. Exactly 14 iterations, then go to GRAVA.
- GRAVA: `bcd` ← accumulator, committed sign ← pending sign, `valido` ← 1, `pronto`=1 for this cycle only, return to OCIOSO.
- Inputs changing during CONVERTE/GRAVA are ignored; they are detected in the following OCIOSO cycle and trigger a new conversion.
- `EN`=0: `seg`=7'h7F and `an`=6'h3F on the next edge; `valido` ← 0, which forces reconversion when `EN` returns to 1. An in-flight conversion still completes and commits.
- Value range 0..16383 always fits in five digits; there is no overflow case.
- Scanning: the prescaler counts 0..SCAN_DIV-1. At wrap, the scan index advances 0→1→…→5→0. The active position drives its `an` bit low. All outputs are registered.
- Digit content: position 0 always shows its digit. Position k (1..4) is blank when it and all higher digits are zero. Position 5 shows minus (`seg`=7'b0111111) when the committed sign is 1 and the value is nonzero, and is blank otherwise.
- `seg` and `an` remain blank until the first commit after reset.

## Timing
- Latency from a sampled change in OCIOSO to `pronto`: 16 cycles (1 sample + 14 convert + 1 commit). `bcd` is valid in the same cycle as `pronto`.
- Displayed digits reflect the new `bcd` no later than the next scan step.
- Scan period: 6·SCAN_DIV cycles. Exactly one `an` bit is low at any time when enabled and `valido`=1.
- Reset asserted mid-conversion: immediate abort, all outputs to their reset values. After release, the FSM begins from OCIOSO with `valido`=0.

## Structure
- Package `display_pkg`: FSM state encoding, `SEG_BLANK`=7'h7F, `SEG_MENOS`=7'b0111111, digit count constants (5 digits, 6 positions).
- Sub-module `decod_7seg`: combinational 4-bit BCD → active-low `seg`, with a blank input. It is instantiated once on the muxed digit.

## Test plan
- Reset then `EN`=1, `Y`=16129, `sinal`=0 → `pronto` 16 cycles later, `bcd`=20'h16129; with SCAN_DIV=4, positions 4..0 show 1,6,1,2,9 and position 5 is blank.
- `Y`=5, `sinal`=1 → `bcd`=20'h00005; position 0 shows "5", position 5 shows minus, positions 1–4 show `seg`=7'h7F.
- `Y`=0, `sinal`=1 → only position 0 shows "0" and the minus sign is suppressed.
- Change `Y` 100→200 at conversion cycle 5 → first commit is 100, second commit is 200 occurring 16 cycles after the first returns to OCIOSO.
- `EN` dropped after a commit → `an`=6'h3F next cycle. `EN` raised again with the same `Y` → a fresh conversion and a `pronto` pulse.
- Assert `rst_n`=0 at conversion cycle 7 → all outputs take their reset values immediately and no `pronto` pulse occurs.
